// File: rtl/pll_reset_seq.sv
// PLL reset sequencer: pulses the PLL reset, waits for lock with bounded
// retries, qualifies lock stability, then releases the core reset.
module pll_reset_seq #(
    parameter int SYNC_STAGES    = 2,
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 500000,
    parameter int STABLE_CYCLES  = 1024,
    parameter int RETRY_MAX      = 7,
    parameter int CNT_W          = 20
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       locked,
    input  logic       soft_reset,
    output logic       pll_rst,
    output logic       core_reset,
    output logic       lock_lost,
    output logic       fail,
    output logic [3:0] retry_count,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_ASSERT_RST = 3'd0,
        S_WAIT_LOCK  = 3'd1,
        S_STABLE     = 3'd2,
        S_RUN        = 3'd3,
        S_FAIL       = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [31:0]      RMAX        = 32'(RETRY_MAX);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lock_s;
    logic [CNT_W-1:0]       cnt;
    state_t                 st;
    logic [3:0]             retry_next;
    logic                   retry_exhausted;

    assign lock_s          = sync_q[SYNC_STAGES-1];
    assign state           = st;
    assign retry_next      = (retry_count == 4'hF) ? 4'hF : retry_count + 4'd1;
    assign retry_exhausted = (RMAX != 32'd0) && ({28'd0, retry_next} >= RMAX);

    // Bring the asynchronous lock indication into the refclk domain
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], locked};
        end
    end

    // Sequencer FSM; outputs are registered alongside the next state
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            st          <= S_ASSERT_RST;
            cnt         <= '0;
            pll_rst     <= 1'b1;
            core_reset  <= 1'b1;
            lock_lost   <= 1'b0;
            fail        <= 1'b0;
            retry_count <= '0;
        end else if (soft_reset) begin
            st          <= S_ASSERT_RST;
            cnt         <= '0;
            pll_rst     <= 1'b1;
            core_reset  <= 1'b1;
            fail        <= 1'b0;
            retry_count <= '0;
        end else begin
            unique case (st)
                S_ASSERT_RST: begin
                    if (cnt == RST_LAST) begin
                        st      <= S_WAIT_LOCK;
                        cnt     <= '0;
                        pll_rst <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_WAIT_LOCK: begin
                    if (lock_s) begin
                        st  <= S_STABLE;
                        cnt <= '0;
                    end else if (cnt == TO_LAST) begin
                        retry_count <= retry_next;
                        cnt         <= '0;
                        pll_rst     <= 1'b1;
                        if (retry_exhausted) begin
                            st   <= S_FAIL;
                            fail <= 1'b1;
                        end else begin
                            st <= S_ASSERT_RST;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_STABLE: begin
                    if (!lock_s) begin
                        st  <= S_WAIT_LOCK;
                        cnt <= '0;
                    end else if (cnt == STABLE_LAST) begin
                        st          <= S_RUN;
                        cnt         <= '0;
                        core_reset  <= 1'b0;
                        retry_count <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    if (!lock_s) begin
                        st         <= S_ASSERT_RST;
                        cnt        <= '0;
                        pll_rst    <= 1'b1;
                        core_reset <= 1'b1;
                        lock_lost  <= 1'b1;
                    end
                end
                S_FAIL: begin
                    cnt <= '0;
                end
                default: begin
                    st         <= S_ASSERT_RST;
                    cnt        <= '0;
                    pll_rst    <= 1'b1;
                    core_reset <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pll_reset_seq.sv
// Testbench for pll_reset_seq: directed scenarios plus randomized lock
// patterns compared against a timestamp-based reference model.
module tb_pll_reset_seq;

    localparam int SYNC = 2;
    localparam int PRC  = 4;
    localparam int LTO  = 50;
    localparam int STC  = 8;
    localparam int RMX  = 3;

    logic       refclk = 1'b0;
    logic       rst = 1'b1;
    logic       locked = 1'b0;
    logic       soft_reset = 1'b0;
    logic       pll_rst;
    logic       core_reset;
    logic       lock_lost;
    logic       fail;
    logic [3:0] retry_count;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;

    pll_reset_seq #(
        .SYNC_STAGES(SYNC),
        .PLL_RST_CYCLES(PRC),
        .LOCK_TIMEOUT(LTO),
        .STABLE_CYCLES(STC),
        .RETRY_MAX(RMX),
        .CNT_W(20)
    ) dut (
        .refclk(refclk),
        .rst(rst),
        .locked(locked),
        .soft_reset(soft_reset),
        .pll_rst(pll_rst),
        .core_reset(core_reset),
        .lock_lost(lock_lost),
        .fail(fail),
        .retry_count(retry_count),
        .state(state)
    );

    always #5 refclk = ~refclk;

    // Reference model: phase plus the edge number at which it was entered;
    // the synchronizer is a history of locked samples.
    localparam int P_RST = 0, P_WAIT = 1, P_STAB = 2, P_RUN = 3, P_FAIL = 4;
    int m_phase, m_t0, m_edge, m_retries;
    bit m_lost;
    bit m_hist[SYNC];

    initial begin
        m_phase = P_RST; m_t0 = 0; m_edge = 0; m_retries = 0; m_lost = 0;
        for (int i = 0; i < SYNC; i++) m_hist[i] = 0;
        forever begin
            bit ls;
            int el;
            @(posedge refclk or posedge rst);
            if (rst) begin
                m_phase = P_RST; m_t0 = 0; m_edge = 0; m_retries = 0; m_lost = 0;
                for (int i = 0; i < SYNC; i++) m_hist[i] = 0;
            end else begin
                m_edge++;
                ls = m_hist[SYNC-1];
                for (int i = SYNC - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
                m_hist[0] = locked;
                el = m_edge - m_t0;
                if (soft_reset) begin
                    m_phase = P_RST; m_t0 = m_edge; m_retries = 0;
                end else if (m_phase == P_RST) begin
                    if (el == PRC) begin m_phase = P_WAIT; m_t0 = m_edge; end
                end else if (m_phase == P_WAIT) begin
                    if (ls) begin
                        m_phase = P_STAB; m_t0 = m_edge;
                    end else if (el == LTO) begin
                        m_retries = (m_retries < 15) ? m_retries + 1 : 15;
                        m_phase = (RMX != 0 && m_retries >= RMX) ? P_FAIL : P_RST;
                        m_t0 = m_edge;
                    end
                end else if (m_phase == P_STAB) begin
                    if (!ls) begin
                        m_phase = P_WAIT; m_t0 = m_edge;
                    end else if (el == STC) begin
                        m_phase = P_RUN; m_t0 = m_edge; m_retries = 0;
                    end
                end else if (m_phase == P_RUN) begin
                    if (!ls) begin m_phase = P_RST; m_t0 = m_edge; m_lost = 1; end
                end
            end
        end
    end

    task automatic step();
        @(posedge refclk);
        @(negedge refclk);
    endtask

    task automatic test_reset();
        rst = 1'b1; locked = 1'b0; soft_reset = 1'b0;
        repeat (3) step();
        checks++;
        if ({pll_rst, core_reset, lock_lost, fail} !== 4'b1100) begin
            errors++;
            $display("FAIL reset_flags: got %b want 1100",
                     {pll_rst, core_reset, lock_lost, fail});
        end
        checks++;
        if (retry_count !== 4'd0 || state !== 3'd0) begin
            errors++;
            $display("FAIL reset_regs: retry=%0d state=%0d want 0 0", retry_count, state);
        end
    endtask

    task automatic test_lock_up();
        int fall = 0;
        int cfall = 0;
        rst = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (fall == 0 && pll_rst === 1'b0) fall = k;
        end
        checks++;
        if (fall != PRC) begin
            errors++;
            $display("FAIL pll_rst_width: fell at edge %0d want %0d", fall, PRC);
        end
        locked = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (core_reset === 1'b0) begin cfall = k; break; end
        end
        checks++;
        if (cfall != SYNC + STC + 1) begin
            errors++;
            $display("FAIL lock_latency: core_reset fell at %0d want %0d", cfall, SYNC + STC + 1);
        end
        checks++;
        if (state !== 3'd3) begin
            errors++;
            $display("FAIL run_state: got %0d want 3", state);
        end
    endtask

    task automatic test_stable_abort();
        int cfall = 0;
        locked = 1'b0; soft_reset = 1'b1;
        step();
        soft_reset = 1'b0;
        repeat (6) step();
        checks++;
        if (state !== 3'd1) begin
            errors++;
            $display("FAIL abort_wait: got state %0d want 1", state);
        end
        locked = 1'b1;
        repeat (5) step();
        checks++;
        if (state !== 3'd2) begin
            errors++;
            $display("FAIL abort_stable: got state %0d want 2", state);
        end
        locked = 1'b0;
        repeat (3) step();
        checks++;
        if (state !== 3'd1 || retry_count !== 4'd0) begin
            errors++;
            $display("FAIL abort_back: state=%0d retry=%0d want 1 0", state, retry_count);
        end
        locked = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (core_reset === 1'b0) begin cfall = k; break; end
        end
        checks++;
        if (cfall != SYNC + STC + 1 || retry_count !== 4'd0) begin
            errors++;
            $display("FAIL abort_relock: fall=%0d retry=%0d want %0d 0",
                     cfall, retry_count, SYNC + STC + 1);
        end
    endtask

    task automatic test_lock_loss();
        int hit = 0;
        int cfall = 0;
        locked = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (core_reset === 1'b1) begin hit = k; break; end
        end
        checks++;
        if (hit != SYNC + 1) begin
            errors++;
            $display("FAIL loss_latency: core_reset rose at %0d want %0d", hit, SYNC + 1);
        end
        checks++;
        if ({pll_rst, lock_lost} !== 2'b11 || state !== 3'd0) begin
            errors++;
            $display("FAIL loss_flags: pll_rst=%b lost=%b state=%0d want 1 1 0",
                     pll_rst, lock_lost, state);
        end
        locked = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            step();
            if (core_reset === 1'b0) begin cfall = k; break; end
        end
        checks++;
        if (cfall == 0 || state !== 3'd3 || lock_lost !== 1'b1) begin
            errors++;
            $display("FAIL loss_relock: fall=%0d state=%0d lost=%b want >0 3 1",
                     cfall, state, lock_lost);
        end
    endtask

    task automatic test_retry_fail();
        int per;
        per = PRC + LTO;
        locked = 1'b0; soft_reset = 1'b1;
        step();
        soft_reset = 1'b0;
        for (int k = 1; k <= 3 * per + 8; k++) begin
            int r;
            step();
            r = k / per;
            if (r < 3 && k % per == PRC - 1) begin
                checks++;
                if (pll_rst !== 1'b1) begin
                    errors++;
                    $display("FAIL retry_rst_hold: edge %0d pll_rst=%b want 1", k, pll_rst);
                end
            end
            if (r < 3 && k % per == PRC) begin
                checks++;
                if (pll_rst !== 1'b0 || state !== 3'd1) begin
                    errors++;
                    $display("FAIL retry_wait: edge %0d pll_rst=%b state=%0d want 0 1",
                             k, pll_rst, state);
                end
            end
            if (k % per == per - 1 && r < 3) begin
                checks++;
                if (retry_count !== 4'(r) || state !== 3'd1) begin
                    errors++;
                    $display("FAIL retry_pre: edge %0d retry=%0d state=%0d want %0d 1",
                             k, retry_count, state, r);
                end
            end
            if (k % per == 0 && r >= 1 && r <= 3) begin
                checks++;
                if (retry_count !== 4'(r) || pll_rst !== 1'b1 ||
                    state !== ((r == 3) ? 3'd4 : 3'd0) || fail !== (r == 3)) begin
                    errors++;
                    $display("FAIL retry_count: edge %0d retry=%0d state=%0d fail=%b want %0d",
                             k, retry_count, state, fail, r);
                end
            end
        end
        checks++;
        if (fail !== 1'b1 || pll_rst !== 1'b1 || state !== 3'd4) begin
            errors++;
            $display("FAIL fail_hold: fail=%b pll_rst=%b state=%0d want 1 1 4",
                     fail, pll_rst, state);
        end
    endtask

    task automatic test_soft_from_fail();
        soft_reset = 1'b1;
        step();
        soft_reset = 1'b0;
        checks++;
        if (fail !== 1'b0 || retry_count !== 4'd0 || state !== 3'd0) begin
            errors++;
            $display("FAIL soft_exit: fail=%b retry=%0d state=%0d want 0 0 0",
                     fail, retry_count, state);
        end
        checks++;
        if (lock_lost !== 1'b1 || pll_rst !== 1'b1 || core_reset !== 1'b1) begin
            errors++;
            $display("FAIL soft_flags: lost=%b pll_rst=%b core=%b want 1 1 1",
                     lock_lost, pll_rst, core_reset);
        end
    endtask

    task automatic test_async_rst();
        int seen = 0;
        locked = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step();
            if (state === 3'd2) begin seen = 1; break; end
        end
        checks++;
        if (seen == 0) begin
            errors++;
            $display("FAIL reach_stable: state=%0d want 2", state);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({pll_rst, core_reset, lock_lost, fail, retry_count, state} !== 11'b1100_0000_000) begin
            errors++;
            $display("FAIL async_rst: got %b want 11000000000",
                     {pll_rst, core_reset, lock_lost, fail, retry_count, state});
        end
        @(negedge refclk);
        locked = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_soft_vs_timeout();
        repeat (PRC + LTO - 1) step();
        checks++;
        if (state !== 3'd1 || retry_count !== 4'd0) begin
            errors++;
            $display("FAIL pre_timeout: state=%0d retry=%0d want 1 0", state, retry_count);
        end
        soft_reset = 1'b1;
        step();
        soft_reset = 1'b0;
        checks++;
        if (state !== 3'd0 || retry_count !== 4'd0 || fail !== 1'b0) begin
            errors++;
            $display("FAIL soft_wins: state=%0d retry=%0d fail=%b want 0 0 0",
                     state, retry_count, fail);
        end
    endtask

    task automatic test_random();
        bit lk = 0;
        int left = 0;
        logic [10:0] exp_v;
        for (int n = 0; n < 4000; n++) begin
            if (left == 0) begin
                lk = ~lk;
                left = lk ? int'($urandom_range(1, 120)) : int'($urandom_range(1, 200));
            end
            left--;
            locked = lk;
            soft_reset = ($urandom_range(0, 299) == 0);
            rst = ($urandom_range(0, 999) == 0);
            step();
            exp_v = {(m_phase == P_RST || m_phase == P_FAIL), (m_phase != P_RUN), m_lost,
                     (m_phase == P_FAIL), 4'(m_retries), 3'(m_phase)};
            checks++;
            if ({pll_rst, core_reset, lock_lost, fail, retry_count, state} !== exp_v) begin
                errors++;
                $display("FAIL random_cycle %0d: got %b want %b", n,
                         {pll_rst, core_reset, lock_lost, fail, retry_count, state}, exp_v);
            end
        end
        rst = 1'b0; soft_reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_lock_up();
        test_stable_abort();
        test_lock_loss();
        test_retry_fail();
        test_soft_from_fail();
        test_async_rst();
        test_soft_vs_timeout();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pll_reset_seq.md
Name: pll_reset_seq

Overview:
- Sequencer on the other end of the PLL wrapper's rst/locked interface: it drives the PLL reset input and consumes its `locked` output.
- Runs on the always-present reference clock (50 MHz board clock).
- Holds the PLL in reset, waits for lock with a timeout and bounded retries, and qualifies lock stability before releasing the core reset.
- Re-sequences automatically on loss of lock.

Parameters:
- SYNC_STAGES, 2, flops in the `locked` synchronizer (>=2).
- PLL_RST_CYCLES, 16, refclk cycles `pll_rst` is held high per attempt (>=1).
- LOCK_TIMEOUT, 500000, refclk cycles allowed in WAIT_LOCK before a retry (10 ms at 50 MHz).
- STABLE_CYCLES, 1024, consecutive synchronized-locked cycles required before release (>=1).
- RETRY_MAX, 7, timeouts before FAIL; 0 = retry forever.
- CNT_W, 20, shared counter width; must hold max(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES).

Ports:
- refclk, input, 1, sole clock.
- rst, input, 1, asynchronous active-high reset.
- locked, input, 1, PLL lock indication, asynchronous to refclk.
- soft_reset, input, 1, synchronous request to restart the sequence.
- pll_rst, output, 1, reset to the PLL.
- core_reset, output, 1, active-high reset to downstream logic.
- lock_lost, output, 1, sticky: lock dropped while in RUN.
- fail, output, 1, high in FAIL state.
- retry_count, output, 4, timeouts since last RUN entry; saturates at 15.
- state, output, 3, current FSM state (debug).

Behaviour:
- Reset values (while rst=1):
  - state=ASSERT_RST, counter=0.
  - pll_rst=1, core_reset=1.
  - lock_lost=0, fail=0, retry_count=0.
  - Synchronizer flops=0.
- All outputs are registered; no combinational paths from inputs to outputs.
- lock_s is `locked` after SYNC_STAGES flops. Only lock_s is used internally.
- Counter clears on every state transition.
- State encoding: ASSERT_RST=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAIL=4.
- ASSERT_RST:
  - pll_rst=1, core_reset=1.
  - Counter increments each cycle.
  - At count PLL_RST_CYCLES-1 → WAIT_LOCK.
  - After rst release, pll_rst is high for exactly PLL_RST_CYCLES edges.
- WAIT_LOCK:
  - pll_rst=0, core_reset=1. Counter increments.
  - lock_s=1 → STABLE. If lock_s=1 and timeout occur on the same cycle, lock wins.
  - Timeout: count LOCK_TIMEOUT-1 with lock_s=0.
    - retry_count increments (saturating).
    - If RETRY_MAX≠0 and the new value ≥ RETRY_MAX → FAIL; otherwise → ASSERT_RST.
- STABLE:
  - pll_rst=0, core_reset=1.
  - lock_s=0 → WAIT_LOCK with a fresh timeout; this is not counted as a retry.
  - At count STABLE_CYCLES-1 with lock_s=1 → RUN.
- RUN:
  - pll_rst=0, core_reset=0. retry_count clears on entry.
  - lock_s=0 → ASSERT_RST. On that same edge: core_reset=1, pll_rst=1, lock_lost=1.
- FAIL:
  - pll_rst=1, core_reset=1, fail=1.
  - Exit only via rst or soft_reset.
- Latencies (edges from the `locked` transition, with setup met):
  - core_reset fall = SYNC_STAGES+STABLE_CYCLES+1.
  - core_reset rise on loss of lock = SYNC_STAGES+1.
- soft_reset:
  - Priority over all FSM transitions; only rst ranks higher.
  - In any state, next edge: state=ASSERT_RST, counter=0, retry_count=0, fail=0, pll_rst=1, core_reset=1.
  - Held high: stays in ASSERT_RST with the counter held at 0.
  - Does not clear lock_lost. Only rst clears lock_lost.
- rst asserted mid-sequence: all registers return to reset values immediately (asynchronous). Sequencing restarts on the first edge after deassertion.
- A locked glitch shorter than one refclk period may be missed. This is acceptable.

Test Plan (bench parameters: SYNC_STAGES=2, PLL_RST_CYCLES=4, LOCK_TIMEOUT=50, STABLE_CYCLES=8, RETRY_MAX=3):
- Release rst, raise `locked` 10 cycles later → pll_rst high exactly 4 edges; core_reset falls exactly 11 edges after `locked` rises; state=3.
- `locked` high 5 cycles, then low 3, then high for good → STABLE aborts to WAIT_LOCK, retry_count stays 0; core_reset falls 11 edges after the final rise.
- In RUN, drop `locked` → core_reset and pll_rst high 3 edges later; lock_lost=1; state=0; relocking returns to RUN with lock_lost still 1.
- `locked` held low → three cycles of (4 edges pll_rst, 50 edges wait); retry_count reads 1, 2, then 3; fail=1 with pll_rst=1 held.
- From FAIL pulse soft_reset for 1 cycle → fail=0, retry_count=0, state=0 next edge; lock_lost is unaffected.
- Assert rst during STABLE, and separately soft_reset on the same cycle as a WAIT_LOCK timeout → all outputs at reset values (rst); soft_reset wins (retry_count=0, state=0).
